iob_serpad_scan: RTL and testbench

- Parametrised poller for N serial-shift-register game pads (NES 8-bit, SNES 16-bit, 4021/4021-style).
- Drives one shared latch and clock line to all pads and samples N_CH data lines in parallel.
- Publishes an atomically updated active-high button word per channel, with one-shot or free-running frame modes.
- Sits between pad pins and the CPU register file or peripheral glue.

---
 rtl/iob_serpad_pkg.sv | 22 ++
 rtl/iob_serpad_tick.sv | 27 ++
 rtl/iob_serpad_scan.sv | 163 ++++++++++++++++
 tb/tb_iob_serpad_scan.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_serpad_pkg.sv
// Shared definitions for the serial game-pad poller: FSM encoding, latch length
// and the channel/bit index helper used for the data and event words.
package iob_serpad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned LATCH_TICKS = 2;

    // Flat index of channel c, shifted bit k
    function automatic int unsigned bit_index(input int unsigned c,
                                              input int unsigned k,
                                              input int unsigned n_bits);
        return c * n_bits + k;
    endfunction

endpackage

// File: rtl/iob_serpad_tick.sv
// Prescaler producing a one-cycle tick every DIV clocks; clr restarts the period.
module iob_serpad_tick #(
    parameter int unsigned DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iob_serpad_scan.sv
// Polls N_CH serial-shift-register game pads and publishes an atomic button word.
// Define IOB_SERPAD_SCAN_EVT_EN to enable the sticky press-event register.
module iob_serpad_scan
    import iob_serpad_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned N_BITS    = 8,
    parameter int unsigned DIV       = 250,
    parameter int unsigned GAP_TICKS = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     auto_mode,
    input  logic                     start,
    input  logic [N_CH-1:0]          pad_q,
    output logic                     pad_latch,
    output logic                     pad_clk,
    output logic                     busy,
    output logic                     frame_valid,
    output logic [N_CH*N_BITS-1:0]   data,
    input  logic                     evt_clr,
    output logic [N_CH*N_BITS-1:0]   press_evt
);

    localparam int unsigned W     = N_CH * N_BITS;
    localparam int unsigned SH_W  = $clog2(W);
    localparam int unsigned IDX_W = $clog2(N_BITS);
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       latch_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [W-1:0]     shift;
    logic [N_CH-1:0]  q_meta;
    logic [N_CH-1:0]  q_sync;
    logic             tick;
    logic             start_frame;

    // Pad data lines are asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_meta <= '0;
            q_sync <= '0;
        end else begin
            q_meta <= pad_q;
            q_sync <= q_meta;
        end
    end

    assign start_frame = (state == ST_IDLE) && en &&
                         (auto_mode ? (gap_cnt == GAP_W'(GAP_TICKS)) : start);

    iob_serpad_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_frame),
        .tick_c (tick)
    );

    // Frame sequencer; en low aborts to idle without touching data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            latch_cnt   <= '0;
            gap_cnt     <= '0;
            shift       <= '0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            data        <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (!en) begin
                state     <= ST_IDLE;
                pad_latch <= 1'b0;
                pad_clk   <= 1'b0;
                busy      <= 1'b0;
                gap_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_frame) begin
                            state     <= ST_LATCH;
                            latch_cnt <= '0;
                            gap_cnt   <= '0;
                            pad_latch <= 1'b1;
                            busy      <= 1'b1;
                        end else if (tick && gap_cnt != GAP_W'(GAP_TICKS)) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    ST_LATCH: begin
                        if (tick) begin
                            if (latch_cnt == 2'(LATCH_TICKS - 1)) begin
                                state     <= ST_LOW;
                                idx       <= '0;
                                pad_latch <= 1'b0;
                            end else begin
                                latch_cnt <= latch_cnt + 2'(1);
                            end
                        end
                    end
                    ST_LOW: begin
                        if (tick) begin
                            for (int unsigned c = 0; c < N_CH; c++) begin
                                shift[SH_W'(bit_index(c, 32'(idx), N_BITS))] <= ~q_sync[c];
                            end
                            if (idx == IDX_W'(N_BITS - 1)) begin
                                state <= ST_DONE;
                            end else begin
                                state   <= ST_HIGH;
                                pad_clk <= 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (tick) begin
                            idx     <= idx + IDX_W'(1);
                            state   <= ST_LOW;
                            pad_clk <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        data        <= shift;
                        frame_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IOB_SERPAD_SCAN_EVT_EN
    // Sticky 0->1 transitions; a new press in the publishing cycle beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_evt <= '0;
        end else if (en && state == ST_DONE) begin
            press_evt <= (evt_clr ? '0 : press_evt) | (shift & ~data);
        end else if (evt_clr) begin
            press_evt <= '0;
        end
    end
`else
    logic unused_evt_clr;
    assign unused_evt_clr = evt_clr;
    assign press_evt      = '0;
`endif

endmodule

// File: tb/tb_iob_serpad_scan.sv
// Directed bench for iob_serpad_scan (N_CH=2, N_BITS=8, DIV=4, GAP_TICKS=3)
// with a behavioural shift-register pad model on each data line.
module tb_iob_serpad_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        auto_mode;
    logic        start;
    logic [1:0]  pad_q;
    logic        pad_latch;
    logic        pad_clk;
    logic        busy;
    logic        frame_valid;
    logic [15:0] data;
    logic        evt_clr;
    logic [15:0] press_evt;

    int n_tests = 0;
    int n_fail  = 0;

    iob_serpad_scan #(
        .N_CH      (2),
        .N_BITS    (8),
        .DIV       (4),
        .GAP_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .auto_mode   (auto_mode),
        .start       (start),
        .pad_q       (pad_q),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .busy        (busy),
        .frame_valid (frame_valid),
        .data        (data),
        .evt_clr     (evt_clr),
        .press_evt   (press_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: wire level of bit pos, reloaded by latch, advanced on pad_clk rise
    logic [7:0] pat0 = 8'hFF;
    logic [7:0] pat1 = 8'hFF;
    logic [2:0] pos  = 3'd0;
    logic       pclk_d = 1'b0;
    always @(posedge clk) begin
        pclk_d <= pad_clk;
        if (pad_latch) pos <= 3'd0;
        else if (pad_clk && !pclk_d) pos <= pos + 3'd1;
    end
    assign pad_q = {pat1[pos], pat0[pos]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a frame (start sampled at edge 0) and observe 120 cycles after it
    task automatic run_frame(input int restart_at, output int fv_cycle, output int fv_cnt,
                             output int latch_len, output int n_pulses,
                             output int w_min, output int w_max);
        int   w;
        logic prev;
        fv_cycle = -1; fv_cnt = 0; latch_len = 0; n_pulses = 0;
        w_min = 1000; w_max = 0; w = 0; prev = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == restart_at - 1) start = 1'b1;
            if (k == restart_at) start = 1'b0;
            if (frame_valid) begin
                fv_cnt++;
                if (fv_cycle < 0) fv_cycle = k;
            end
            if (pad_latch) latch_len++;
            if (pad_clk) begin
                if (!prev) n_pulses++;
                w++;
            end else if (prev) begin
                if (w < w_min) w_min = w;
                if (w > w_max) w_max = w;
                w = 0;
            end
            prev = pad_clk;
        end
    endtask

    task automatic pulse_evt_clr();
        @(negedge clk) evt_clr = 1'b1;
        @(negedge clk) evt_clr = 1'b0;
    endtask

    int fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max;
    int t_fv [4];
    int n_fv;
    int cnt;
    logic [15:0] exp_evt5;

    initial begin
`ifdef IOB_SERPAD_SCAN_EVT_EN
        exp_evt5 = 16'h0005;
`else
        exp_evt5 = 16'h0000;
`endif
        rst = 1'b1; en = 1'b1; auto_mode = 1'b0; start = 1'b0; evt_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, pad_latch, pad_clk, busy, frame_valid}, 32'd0);
        check("rst_data", data, 32'h0);
        check("rst_evt", press_evt, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame: pad0 wire 01111110 (bit0 first), pad1 idle
        pat0 = 8'b0111_1110; pat1 = 8'hFF;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("f1_fv_cycle", fv_cycle, 32'd69);
        check("f1_fv_count", fv_cnt, 32'd1);
        check("f1_data", data, 32'h0081);
        check("f1_latch_len", latch_len, 32'd8);
        check("f1_clk_pulses", n_pulses, 32'd7);
        check("f1_clk_wmin", w_min, 32'd4);
        check("f1_clk_wmax", w_max, 32'd4);
        check("f1_busy_after", busy, 32'd0);

        // Start while busy is dropped
        pat0 = 8'hAA; pat1 = 8'h0F;
        run_frame(30, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("f2_fv_cycle", fv_cycle, 32'd69);
        check("f2_fv_count", fv_cnt, 32'd1);
        check("f2_data", data, 32'hF055);

        // Free-running frames
        @(negedge clk) auto_mode = 1'b1;
        n_fv = 0;
        for (int i = 0; i < 4; i++) t_fv[i] = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (frame_valid && n_fv < 4) begin
                t_fv[n_fv] = k;
                n_fv++;
            end
        end
        check("auto_frames", 32'(n_fv), 32'd4);
        check("auto_period1", 32'((t_fv[1] - t_fv[0]) >= 80 && (t_fv[1] - t_fv[0]) <= 82), 32'd1);
        check("auto_period2", 32'((t_fv[2] - t_fv[1]) >= 80 && (t_fv[2] - t_fv[1]) <= 82), 32'd1);
        check("auto_data", data, 32'hF055);
        auto_mode = 1'b0;
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
        check("auto_stop_idle", busy, 32'd0);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_valid) cnt++;
        end
        check("auto_stop_nofv", cnt, 32'd0);

        // Abort by en during a pad_clk high phase
        pat0 = 8'b0111_1110; pat1 = 8'hFF;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("ab_prior_data", data, 32'h0081);
        pat0 = 8'h00; pat1 = 8'h00;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        check("ab_pre_clk", pad_clk, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("ab_latch", pad_latch, 32'd0);
        check("ab_clk", pad_clk, 32'd0);
        check("ab_busy", busy, 32'd0);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_valid) cnt++;
        end
        check("ab_nofv", cnt, 32'd0);
        check("ab_data_kept", data, 32'h0081);
        en = 1'b1;

        // Asynchronous reset in the middle of a frame
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        check("rm_pre_clk", pad_clk, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rm_ctrl", {28'd0, pad_latch, pad_clk, busy, frame_valid}, 32'd0);
        check("rm_data", data, 32'h0);
        @(negedge clk) rst = 1'b0;
        pat0 = 8'hF0; pat1 = 8'h3C;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("rm_fv_cycle", fv_cycle, 32'd69);
        check("rm_fv_count", fv_cnt, 32'd1);
        check("rm_data_after", data, 32'hC30F);

        // Press events: 0x00 -> 0x05 -> 0x04
        pat0 = 8'hFF; pat1 = 8'hFF;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("ev_data0", data, 32'h0000);
        pulse_evt_clr();
        check("ev_cleared0", press_evt, 32'h0);
        pat0 = 8'hFA;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("ev_data1", data, 32'h0005);
        check("ev_evt1", press_evt, 32'(exp_evt5));
        pat0 = 8'hFB;
        run_frame(-1, fv_cycle, fv_cnt, latch_len, n_pulses, w_min, w_max);
        check("ev_data2", data, 32'h0004);
        check("ev_evt2", press_evt, 32'(exp_evt5));
        pulse_evt_clr();
        check("ev_cleared", press_evt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
